regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with write-first read bypass, a per-register busy scoreboard, and a multi-cycle bulk-clear sequencer. It has one write port and two registered read ports. It replaces the fixed 16x16 register file in the datapath and feeds the ALU operand latches (Rx, Ry). The scoreboard lets the control unit stall when an operand has an outstanding producer.

## Interface
Parameters:
- WIDTH, 16, data width of each register and of Rz/Rx/Ry
- DEPTH, 16, number of registers; power of two, minimum 2
- AW, 4, address width; must equal log2(DEPTH)

Ports:
- clk  in  1  the single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- WR  in  1  write enable for port z
- z  in  AW  write address
- Rz  in  WIDTH  write data
- RD  in  1  read enable for ports x and y
- x  in  AW  read address A
- y  in  AW  read address B
- rsv  in  1  reserve request; sets the busy bit of rsv_addr
- rsv_addr  in  AW  register to reserve
- clr_start  in  1  starts a bulk clear
- Rx  out  WIDTH  registered read data A
- Ry  out  WIDTH  registered read data B
- busy_x  out  1  registered busy bit of register x
- busy_y  out  1  registered busy bit of register y
- clr_busy  out  1  high while a bulk clear is in progress

## Operation
- State:
  - reg[0..DEPTH-1], each WIDTH bits
  - busy[0..DEPTH-1]
  - sweep pointer ptr (AW bits)
  - clr_busy flag
- Reset (reset=1 at the edge): all reg, busy, Rx, Ry, busy_x, busy_y, ptr and clr_busy are cleared to 0. Reset overrides every other input.
- FSM has two states:
  - IDLE (clr_busy=0). If clr_start=1, go to SWEEP with ptr=0. Otherwise stay.
  - SWEEP (clr_busy=1). Each edge writes reg[ptr]=0 and busy[ptr]=0, then increments ptr. On the edge that clears reg[DEPTH-1], return to IDLE; ptr wraps to 0.
- Write: accepted only when WR=1 and the block is in IDLE. An accepted write sets reg[z]=Rz and clears busy[z] (release).
  - In the cycle clr_start is taken from IDLE, that cycle's write is still accepted.
  - In SWEEP, WR is ignored (dropped, not queued).
- Reserve: accepted only when rsv=1 and the block is in IDLE. Sets busy[rsv_addr].
  - rsv and an accepted WR to the same address in one cycle leave busy set (reserve wins).
  - rsv and WR to different addresses both take effect.
- clr_start while in SWEEP is ignored; the sweep does not restart.
- Read: when RD=1, the edge loads Rx/busy_x and Ry/busy_y with the post-edge (next-state) contents of registers x and y. This is write-first:
  - An accepted write to x returns Rz on Rx with busy_x=0.
  - A sweep clear of x in that edge returns 0 on Rx with busy_x=0.
  - A same-cycle reserve of x returns busy_x=1.
  - x==y is legal; both ports return identical data.
- When RD=0, Rx, Ry, busy_x and busy_y hold their previous values.
- Reads are allowed in both IDLE and SWEEP.
- Address inputs are always in range by construction; no wrap or clamp logic is needed.

## Timing
- Read latency is 1 cycle: Rx/Ry are valid after the edge on which RD=1 is sampled.
- Write-to-read latency is 0 extra cycles, via the bypass. A write and a read of the same address in one cycle return the new data at the same edge.
- Bulk clear:
  - clr_busy rises on the edge that samples clr_start.
  - It stays high for exactly DEPTH cycles; register k is cleared on the (k+1)-th edge after that start edge.
  - clr_busy falls on the edge that clears reg[DEPTH-1].
  - A new clr_start is accepted in the first cycle with clr_busy=0.
- Reset asserted mid-sweep aborts the sweep at the next edge. All registers become 0 regardless of ptr.
- No combinational path from any input to any output.

## Test plan
- Reset, then WR z=3 Rz=0xBEEF; next cycle RD x=3 y=0 -> Rx=0xBEEF, Ry=0x0000, busy_x=0.
- Same-cycle bypass: WR z=5 Rz=0x1234 with RD x=5 y=5 -> at that edge Rx=Ry=0x1234. Then RD=0 with Rz changing -> Rx/Ry hold 0x1234.
- Scoreboard: rsv rsv_addr=7, then RD x=7 -> busy_x=1. WR z=7 Rz=0x0042 -> next read gives busy_x=0, Rx=0x0042. rsv and WR both to addr 2 in one cycle -> busy_y=1 on read of y=2.
- Bulk clear with DEPTH=16:
  - Fill every register with 0xA5A5, then pulse clr_start -> clr_busy high for exactly 16 cycles.
  - Reading x=15 during cycles 1-15 returns 0xA5A5, then 0 afterwards.
  - WR issued mid-sweep is dropped: reg stays 0 after the sweep.
  - A second clr_start mid-sweep does not extend clr_busy.
- Reset mid-sweep: assert reset at sweep cycle 4 -> next edge clr_busy=0, all reads return 0 and busy=0.
- Parameter sweep: WIDTH=32, DEPTH=4, AW=2 -> write 0xFFFFFFFF to reg 3, read back intact. Bulk clear lasts 4 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb
//   Parametrised register file: one write port (z/Rz), two registered read
//   ports (x -> Rx, y -> Ry) with write-first bypass, a per-register busy
//   scoreboard, and a bulk-clear sequencer that zeroes one register per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every register and output
//   WR, z, Rz  write enable / address / data (accepted only while idle)
//   RD, x, y   read enable / addresses; Rx, Ry, busy_x, busy_y load on RD
//   rsv        reserve request, sets busy[rsv_addr] (accepted only while idle)
//   rsv_addr   register to reserve
//   clr_start  starts a bulk clear from idle
//   Rx, Ry     registered read data
//   busy_x/y   registered busy bits of the addressed registers
//   clr_busy   high while a bulk clear is sweeping
module regfile_sb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WR,
    input  logic [AW-1:0]    z,
    input  logic [WIDTH-1:0] Rz,
    input  logic             RD,
    input  logic [AW-1:0]    x,
    input  logic [AW-1:0]    y,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             clr_start,
    output logic [WIDTH-1:0] Rx,
    output logic [WIDTH-1:0] Ry,
    output logic             busy_x,
    output logic             busy_y,
    output logic             clr_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] regs_nxt [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Next-state of the whole array. The read ports sample this rather than
    // the current contents, which is what gives write-first behaviour for
    // writes, reserves and sweep clears alike.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = busy;
        for (int i = 0; i < DEPTH; i++) begin
            regs_nxt[i] = regs[i];
        end

        case (state)
            IDLE: begin
                if (WR) begin
                    regs_nxt[z] = Rz;
                    busy_nxt[z] = 1'b0;
                end
                // Applied after the write so a same-address reserve wins.
                if (rsv) begin
                    busy_nxt[rsv_addr] = 1'b1;
                end
                if (clr_start) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                regs_nxt[ptr] = '0;
                busy_nxt[ptr] = 1'b0;
                // ptr is exactly AW bits wide, so it wraps to 0 on its own.
                ptr_nxt       = ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            busy   <= '0;
            Rx     <= '0;
            Ry     <= '0;
            busy_x <= 1'b0;
            busy_y <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            busy  <= busy_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            if (RD) begin
                Rx     <= regs_nxt[x];
                Ry     <= regs_nxt[y];
                busy_x <= busy_nxt[x];
                busy_y <= busy_nxt[y];
            end
        end
    end

    assign clr_busy = (state == SWEEP);

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus a randomized run checked
// against a behavioural model, and a second instance at WIDTH=32/DEPTH=4.
module tb_regfile_sb;

    localparam int W = 16;
    localparam int D = 16;
    localparam int A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, WR, RD, rsv, clr_start;
    logic [A-1:0] z, x, y, rsv_addr;
    logic [W-1:0] Rz;
    logic [W-1:0] Rx, Ry;
    logic         busy_x, busy_y, clr_busy;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk(clk), .reset(reset), .WR(WR), .z(z), .Rz(Rz), .RD(RD), .x(x), .y(y),
        .rsv(rsv), .rsv_addr(rsv_addr), .clr_start(clr_start),
        .Rx(Rx), .Ry(Ry), .busy_x(busy_x), .busy_y(busy_y), .clr_busy(clr_busy)
    );

    logic        b_reset, b_WR, b_RD, b_rsv, b_clr;
    logic [1:0]  b_z, b_x, b_y, b_ra;
    logic [31:0] b_Rz, b_Rx, b_Ry;
    logic        b_bx, b_by, b_cb;

    regfile_sb #(.WIDTH(32), .DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .reset(b_reset), .WR(b_WR), .z(b_z), .Rz(b_Rz), .RD(b_RD), .x(b_x), .y(b_y),
        .rsv(b_rsv), .rsv_addr(b_ra), .clr_start(b_clr),
        .Rx(b_Rx), .Ry(b_Ry), .busy_x(b_bx), .busy_y(b_by), .clr_busy(b_cb)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of the 16x16 instance.
    logic [W-1:0] m_reg [D];
    bit           m_busy[D];
    int           sweep_left = 0;   // remaining sweep edges; 0 means idle
    int           sweep_idx  = 0;
    logic [W-1:0] e_rx, e_ry;
    logic         e_bx, e_by;

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            sweep_left = 0;
            sweep_idx  = 0;
            e_rx = '0; e_ry = '0; e_bx = 1'b0; e_by = 1'b0;
        end else begin
            if (sweep_left == 0) begin
                if (WR) begin
                    m_reg[z]  = Rz;
                    m_busy[z] = 1'b0;
                end
                if (rsv) m_busy[rsv_addr] = 1'b1;
                if (clr_start) begin
                    sweep_left = D;
                    sweep_idx  = 0;
                end
            end else begin
                m_reg[sweep_idx]  = '0;
                m_busy[sweep_idx] = 1'b0;
                sweep_idx++;
                sweep_left--;
            end
            if (RD) begin
                e_rx = m_reg[x]; e_ry = m_reg[y];
                e_bx = m_busy[x]; e_by = m_busy[y];
            end
        end
    endtask

    // Every clock edge goes through here so the model never falls behind.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; WR = 1'b0; RD = 1'b0; rsv = 1'b0; clr_start = 1'b0;
        z = '0; x = '0; y = '0; rsv_addr = '0; Rz = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; WR = 1'b1; z = 4'd1; Rz = 16'hFFFF; RD = 1'b1; x = 4'd1; y = 4'd1;
        rsv = 1'b1; rsv_addr = 4'd1; clr_start = 1'b1;
        cyc();
        compared++; if (Rx !== 16'h0) begin mismatched++; $display("FAIL reset_rx: got %h want 0000", Rx); end
        compared++; if (Ry !== 16'h0) begin mismatched++; $display("FAIL reset_ry: got %h want 0000", Ry); end
        compared++; if (busy_x !== 1'b0) begin mismatched++; $display("FAIL reset_bx: got %b want 0", busy_x); end
        compared++; if (busy_y !== 1'b0) begin mismatched++; $display("FAIL reset_by: got %b want 0", busy_y); end
        compared++; if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
        idle_inputs();
        RD = 1'b1; x = 4'd1; y = 4'd1;
        cyc();
        compared++; if (Rx !== 16'h0) begin mismatched++; $display("FAIL reset_reg1: got %h want 0000", Rx); end
    endtask

    task automatic test_write_read();
        idle_inputs();
        WR = 1'b1; z = 4'd3; Rz = 16'hBEEF;
        cyc();
        idle_inputs();
        RD = 1'b1; x = 4'd3; y = 4'd0;
        cyc();
        compared++; if (Rx !== 16'hBEEF) begin mismatched++; $display("FAIL wr_rd_rx: got %h want beef", Rx); end
        compared++; if (Ry !== 16'h0000) begin mismatched++; $display("FAIL wr_rd_ry: got %h want 0000", Ry); end
        compared++; if (busy_x !== 1'b0) begin mismatched++; $display("FAIL wr_rd_bx: got %b want 0", busy_x); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        WR = 1'b1; z = 4'd5; Rz = 16'h1234; RD = 1'b1; x = 4'd5; y = 4'd5;
        cyc();
        compared++; if (Rx !== 16'h1234) begin mismatched++; $display("FAIL bypass_rx: got %h want 1234", Rx); end
        compared++; if (Ry !== 16'h1234) begin mismatched++; $display("FAIL bypass_ry: got %h want 1234", Ry); end
        // RD low: outputs hold even though register 5 is rewritten.
        idle_inputs();
        WR = 1'b1; z = 4'd5; Rz = 16'h5555; x = 4'd5; y = 4'd3;
        cyc();
        Rz = 16'h9999; WR = 1'b0;
        cyc();
        compared++; if (Rx !== 16'h1234) begin mismatched++; $display("FAIL hold_rx: got %h want 1234", Rx); end
        compared++; if (Ry !== 16'h1234) begin mismatched++; $display("FAIL hold_ry: got %h want 1234", Ry); end
        idle_inputs();
        RD = 1'b1; x = 4'd5; y = 4'd5;
        cyc();
        compared++; if (Rx !== 16'h5555) begin mismatched++; $display("FAIL hold_then_read: got %h want 5555", Rx); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rsv = 1'b1; rsv_addr = 4'd7;
        cyc();
        idle_inputs();
        RD = 1'b1; x = 4'd7;
        cyc();
        compared++; if (busy_x !== 1'b1) begin mismatched++; $display("FAIL rsv_bx: got %b want 1", busy_x); end
        idle_inputs();
        WR = 1'b1; z = 4'd7; Rz = 16'h0042;
        cyc();
        idle_inputs();
        RD = 1'b1; x = 4'd7;
        cyc();
        compared++; if (busy_x !== 1'b0) begin mismatched++; $display("FAIL release_bx: got %b want 0", busy_x); end
        compared++; if (Rx !== 16'h0042) begin mismatched++; $display("FAIL release_rx: got %h want 0042", Rx); end
        idle_inputs();
        rsv = 1'b1; rsv_addr = 4'd2; WR = 1'b1; z = 4'd2; Rz = 16'h0077;
        cyc();
        idle_inputs();
        RD = 1'b1; x = 4'd0; y = 4'd2;
        cyc();
        compared++; if (busy_y !== 1'b1) begin mismatched++; $display("FAIL rsv_wins_by: got %b want 1", busy_y); end
        compared++; if (Ry !== 16'h0077) begin mismatched++; $display("FAIL rsv_wins_ry: got %h want 0077", Ry); end
        // Reserve and write to different addresses, read both in the same edge.
        idle_inputs();
        rsv = 1'b1; rsv_addr = 4'd9; WR = 1'b1; z = 4'd10; Rz = 16'hCAFE;
        RD = 1'b1; x = 4'd9; y = 4'd10;
        cyc();
        compared++; if (busy_x !== 1'b1) begin mismatched++; $display("FAIL rsv_bypass_bx: got %b want 1", busy_x); end
        compared++; if (busy_y !== 1'b0) begin mismatched++; $display("FAIL wr_diff_by: got %b want 0", busy_y); end
        compared++; if (Ry !== 16'hCAFE) begin mismatched++; $display("FAIL wr_diff_ry: got %h want cafe", Ry); end
    endtask

    task automatic test_bulk_clear();
        int count;
        logic [W-1:0] want;
        for (int i = 0; i < D; i++) begin
            idle_inputs();
            WR = 1'b1; z = A'(i); Rz = 16'hA5A5;
            cyc();
        end
        idle_inputs();
        clr_start = 1'b1; RD = 1'b1; x = 4'd15; y = 4'd0;
        cyc();
        count = 0;
        compared++; if (clr_busy !== 1'b1) begin mismatched++; $display("FAIL clr_rise: got %b want 1", clr_busy); end
        compared++; if (Rx !== 16'hA5A5) begin mismatched++; $display("FAIL clr_start_rx: got %h want a5a5", Rx); end
        if (clr_busy === 1'b1) count = 1;
        for (int k = 1; k <= 40; k++) begin
            WR = (k == 5); z = 4'd9; Rz = 16'h1111;
            clr_start = (k == 8);
            cyc();
            want = (k < D) ? 16'hA5A5 : 16'h0000;
            compared++;
            if (Rx !== want) begin mismatched++; $display("FAIL sweep_rx_k%0d: got %h want %h", k, Rx, want); end
            if (clr_busy !== 1'b1) break;
            count++;
        end
        compared++; if (count !== D) begin mismatched++; $display("FAIL clr_len: got %0d want %0d", count, D); end
        idle_inputs();
        RD = 1'b1; x = 4'd9; y = 4'd0;
        cyc();
        compared++; if (Rx !== 16'h0) begin mismatched++; $display("FAIL dropped_wr: got %h want 0000", Rx); end
        compared++; if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL no_restart: got %b want 0", clr_busy); end
        // A fresh clr_start right after the sweep ends is accepted.
        idle_inputs();
        clr_start = 1'b1;
        cyc();
        compared++; if (clr_busy !== 1'b1) begin mismatched++; $display("FAIL clr_reaccept: got %b want 1", clr_busy); end
        idle_inputs();
        for (int k = 0; k < D; k++) cyc();
        compared++; if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL clr_reaccept_end: got %b want 0", clr_busy); end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < D; i++) begin
            idle_inputs();
            WR = 1'b1; z = A'(i); Rz = 16'h3C00 | 16'(i);
            cyc();
        end
        for (int i = 12; i < D; i++) begin
            idle_inputs();
            rsv = 1'b1; rsv_addr = A'(i);
            cyc();
        end
        idle_inputs();
        clr_start = 1'b1;
        cyc();
        idle_inputs();
        for (int k = 1; k < 4; k++) cyc();
        reset = 1'b1;
        cyc();
        compared++; if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL rst_sweep_clr_busy: got %b want 0", clr_busy); end
        for (int i = 0; i < D; i++) begin
            idle_inputs();
            RD = 1'b1; x = A'(i); y = A'(D - 1 - i);
            cyc();
            compared++;
            if (Rx !== 16'h0 || Ry !== 16'h0 || busy_x !== 1'b0 || busy_y !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_sweep_read_%0d: got Rx=%h Ry=%h bx=%b by=%b want all 0", i, Rx, Ry, busy_x, busy_y);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            WR        = 1'($urandom_range(0, 1));
            z         = A'($urandom);
            Rz        = W'($urandom);
            RD        = ($urandom_range(0, 3) != 0);
            x         = A'($urandom);
            y         = ($urandom_range(0, 7) == 0) ? x : A'($urandom);
            rsv       = ($urandom_range(0, 2) == 0);
            rsv_addr  = ($urandom_range(0, 3) == 0) ? z : A'($urandom);
            clr_start = ($urandom_range(0, 29) == 0);
            cyc();
            compared++;
            if (Rx !== e_rx || Ry !== e_ry || busy_x !== e_bx || busy_y !== e_by ||
                clr_busy !== (sweep_left != 0)) begin
                mismatched++;
                $display("FAIL rand_%0d: got Rx=%h Ry=%h bx=%b by=%b cb=%b want Rx=%h Ry=%h bx=%b by=%b cb=%b",
                         n, Rx, Ry, busy_x, busy_y, clr_busy, e_rx, e_ry, e_bx, e_by, sweep_left != 0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_param();
        int count;
        b_reset = 1'b0; b_WR = 1'b1; b_z = 2'd3; b_Rz = 32'hFFFF_FFFF;
        cyc();
        b_WR = 1'b0; b_RD = 1'b1; b_x = 2'd3; b_y = 2'd2;
        cyc();
        compared++; if (b_Rx !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL p32_rx: got %h want ffffffff", b_Rx); end
        compared++; if (b_Ry !== 32'h0) begin mismatched++; $display("FAIL p32_ry: got %h want 00000000", b_Ry); end
        b_RD = 1'b0; b_clr = 1'b1;
        cyc();
        b_clr = 1'b0;
        compared++; if (b_cb !== 1'b1) begin mismatched++; $display("FAIL p4_clr_rise: got %b want 1", b_cb); end
        count = (b_cb === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (b_cb !== 1'b1) break;
            count++;
        end
        compared++; if (count !== 4) begin mismatched++; $display("FAIL p4_clr_len: got %0d want 4", count); end
        b_RD = 1'b1; b_x = 2'd3; b_y = 2'd3;
        cyc();
        compared++; if (b_Rx !== 32'h0) begin mismatched++; $display("FAIL p4_cleared: got %h want 00000000", b_Rx); end
        b_RD = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        b_reset = 1'b1; b_WR = 1'b0; b_RD = 1'b0; b_rsv = 1'b0; b_clr = 1'b0;
        b_z = '0; b_x = '0; b_y = '0; b_ra = '0; b_Rz = '0;
        cyc();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_bulk_clear();
        test_reset_mid_sweep();
        test_random();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
